// File: rtl/o_buf_drain.sv
// Drains the output accumulation buffer: sweeps addresses, applies ReLU / rounding shift /
// saturation, streams results through a small FIFO and optionally re-seeds entries with a bias.
module o_buf_drain #(
  parameter int unsigned Width     = 32,
  parameter int unsigned Depth     = 8,
  parameter int unsigned OutWidth  = 8,
  parameter int unsigned FifoDepth = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  input  logic [$clog2(Depth):0]     len_i,
  input  logic [4:0]                 shift_i,
  input  logic                       relu_en_i,
  input  logic                       reinit_en_i,
  input  logic [Width-1:0]           bias_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [$clog2(Depth)-1:0]   raddr_o,
  input  logic [Width-1:0]           rdata_i,
  output logic [Width-1:0]           cdata_o,
  output logic                       cw_vo,
  output logic [OutWidth-1:0]        out_data_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned LenW  = AddrW + 1;
  localparam int unsigned PtrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int unsigned CntW  = $clog2(FifoDepth + 1);

  localparam logic signed [Width:0] SatMax = (Width+1)'((2 ** (OutWidth - 1)) - 1);
  localparam logic signed [Width:0] SatMin = ~SatMax;

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e               state_q, state_d;
  logic [LenW-1:0]      cnt_q, cnt_d;
  logic [LenW-1:0]      len_q;
  logic [AddrW-1:0]     raddr_q;
  logic [4:0]           shift_q;
  logic                 relu_q;
  logic                 reinit_q;
  logic [Width-1:0]     bias_q;
  logic                 inflight_q;
  logic                 done_q, done_d;
  logic                 latch_cfg;

  logic [OutWidth-1:0]  fifo_q [FifoDepth];
  logic [PtrW-1:0]      rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]      fifo_cnt_q;

  logic                 issue;
  logic                 push;
  logic                 pop;
  logic [CntW:0]        occ;

  logic signed [Width-1:0] relu_v;
  logic signed [Width:0]   ext_v;
  logic signed [Width:0]   rnd_v;
  logic signed [Width:0]   shr_v;
  logic [OutWidth-1:0]     proc_v;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(FifoDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign out_valid_o = (fifo_cnt_q != '0);
  assign out_data_o  = fifo_q[rd_ptr_q];
  assign pop         = out_valid_o & out_ready_i;
  assign push        = inflight_q;

  // Slots already committed (stored + returning) minus the one leaving this cycle.
  assign occ   = {1'b0, fifo_cnt_q} + {{CntW{1'b0}}, inflight_q} - {{CntW{1'b0}}, pop};
  assign issue = (state_q == StRun) && (occ < (CntW+1)'(FifoDepth));

  assign raddr_o = issue ? cnt_q[AddrW-1:0] : raddr_q;
  assign cw_vo   = issue & reinit_q;
  assign cdata_o = bias_q;
  assign busy_o  = (state_q != StIdle);
  assign done_o  = done_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    latch_cfg = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          if (len_i == '0) begin
            done_d = 1'b1;
          end else begin
            state_d   = StRun;
            cnt_d     = '0;
            latch_cfg = 1'b1;
          end
        end
      end
      StRun: begin
        if (issue) begin
          cnt_d = cnt_q + LenW'(1);
          if (cnt_q + LenW'(1) == len_q) state_d = StDrain;
        end
      end
      StDrain: begin
        if (!inflight_q && (fifo_cnt_q == '0)) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Post-processing of the returning word; the extra bit keeps the rounding add exact.
  always_comb begin
    relu_v = $signed(rdata_i);
    if (relu_q && (relu_v < 0)) relu_v = '0;
    ext_v = {relu_v[Width-1], relu_v};
    rnd_v = '0;
    shr_v = ext_v;
    if (shift_q != 5'd0) begin
      rnd_v = $signed((Width+1)'(1) << (shift_q - 5'd1));
      shr_v = (ext_v + rnd_v) >>> shift_q;
    end
    if (shr_v > SatMax) begin
      proc_v = SatMax[OutWidth-1:0];
    end else if (shr_v < SatMin) begin
      proc_v = SatMin[OutWidth-1:0];
    end else begin
      proc_v = shr_v[OutWidth-1:0];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      len_q      <= '0;
      raddr_q    <= '0;
      shift_q    <= '0;
      relu_q     <= 1'b0;
      reinit_q   <= 1'b0;
      bias_q     <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      for (int i = 0; i < int'(FifoDepth); i++) fifo_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      inflight_q <= issue;
      raddr_q    <= raddr_o;
      if (latch_cfg) begin
        len_q    <= len_i;
        shift_q  <= shift_i;
        relu_q   <= relu_en_i;
        reinit_q <= reinit_en_i;
        bias_q   <= bias_i;
      end
      if (push) begin
        fifo_q[wr_ptr_q] <= proc_v;
        wr_ptr_q         <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + CntW'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - CntW'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

endmodule

// File: doc/o_buf_drain.md
Name: o_buf_drain

Overview:
- Downstream companion to the output accumulation buffer.
- On start, it sweeps buffer addresses 0..len-1 and captures each read word (buffer read latency is one cycle).
- Each word is post-processed (optional ReLU, rounding arithmetic right shift, signed saturation) and streamed out on a valid/ready interface.
- Optionally re-initialises each buffer entry to a bias value, through the buffer's bias-write port, in the same cycle the entry is read. This readies the buffer for the next tile.

Parameters:
- width, 32: buffer word width, signed two's complement.
- depth, 8: number of buffer entries.
- out_width, 8: output word width, signed.
- fifo_depth, 2: output FIFO entries, minimum 2.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  start pulse; sampled only in IDLE.
- len_i  in  $clog2(depth)+1  entry count to drain, valid 0..depth; latched at start.
- shift_i  in  5  right-shift amount, 0..31; latched at start.
- relu_en_i  in  1  ReLU enable; latched at start.
- reinit_en_i  in  1  re-initialise entries on read; latched at start.
- bias_i  in  width  re-init value; latched at start.
- busy_o  out  1  high in RUN and DRAIN.
- done_o  out  1  one-cycle pulse when the sweep completes.
- raddr_o  out  $clog2(depth)  buffer read address.
- rdata_i  in  width  buffer read data; valid one cycle after raddr_o.
- cdata_o  out  width  bias write data (the latched bias).
- cw_vo  out  1  bias write enable to the buffer.
- out_data_o  out  out_width  processed word.
- out_valid_o  out  1  output valid.
- out_ready_i  in  1  consumer ready.

Behaviour:
- Reset (synchronous, rst_i high at a clock edge):
  - State goes to IDLE; FIFO and in-flight flag are flushed.
  - busy_o, done_o, cw_vo and out_valid_o are 0; raddr_o, cdata_o and out_data_o are 0.
  - Reset mid-operation abandons the sweep: no done_o, and no further cw_vo.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start_i with len_i != 0. Config is latched and the address counter is cleared.
  - start_i with len_i == 0: done_o pulses the next cycle and the state stays IDLE.
  - start_i in RUN or DRAIN is ignored.
  - RUN -> DRAIN in the cycle after the final (len-th) read is issued.
  - DRAIN -> IDLE when the in-flight flag is clear and the FIFO is empty. done_o pulses in the cycle after the FIFO empties; busy_o falls in that same cycle.
- Read issue (RUN only):
  - Issue condition: fifo_count + inflight - pop < fifo_depth, where pop = out_valid_o & out_ready_i.
  - On issue: raddr_o = current counter, the counter increments, and inflight is set for one cycle.
  - The returning rdata_i is processed and pushed into the FIFO in the following cycle.
  - With out_ready_i held high, throughput is one word per cycle.
  - raddr_o holds its value when no read is issued.
- Re-init: when reinit_en is latched, cw_vo = 1 in exactly the issue cycles, with cdata_o = bias. The buffer returns the pre-write value for that same address. cw_vo is never asserted outside RUN.
- System rule: the drain is run only while upstream accumulation writes are idle. This block does not arbitrate against them.
- Post-processing pipeline, in order:
  - ReLU: if enabled and the value is negative, it becomes 0.
  - Rounding shift: if shift > 0, v = (v + 2^(shift-1)) >>> shift, computed at width+1 bits so the add cannot overflow. If shift = 0, v is unchanged.
  - Saturation: clamp to [-2^(out_width-1), 2^(out_width-1)-1].
- Output:
  - FIFO order equals address order.
  - out_data_o and out_valid_o are driven from the FIFO head.
  - Data is stable while out_valid_o = 1 and out_ready_i = 0.
  - Push and pop in the same cycle are allowed.
  - The FIFO never overflows, because the issue condition guarantees it.
- Address counter: counts 0..len-1. With len = depth, the last address is depth-1 and the counter does not wrap during the sweep.

Test Plan:
- Defaults, shift = 4, relu off, buffer = {1000, 5000, -100, -5000, 0, 7, 8, -8}, len = 8, ready held high -> outputs {63, 127, -6, -128, 0, 0, 1, 0}; one word per cycle after a 2-cycle start latency; single done_o pulse.
- Same data with relu on -> {63, 127, 0, 0, 0, 0, 1, 0}.
- out_ready_i toggled 1,0,0,1,... with len = 8 -> no word lost or duplicated, out_data_o stable while stalled, raddr_o never runs more than fifo_depth ahead of accepted words.
- reinit_en = 1, bias = 5 -> cw_vo high exactly on the 8 issue cycles, all buffer entries equal 5 afterwards, streamed values are the pre-bias contents.
- len = 0 -> done_o pulses one cycle after start, no raddr activity, no cw_vo. len = 3 -> addresses 0, 1, 2 only.
- rst_i asserted during RUN after 3 words -> next cycle out_valid_o = 0, busy_o = 0, no done_o. A fresh start then drains from address 0.
